vga_write_arbiter: RTL and testbench

//   Shares the single pixel-write port (x, y, colour, plot) of the 160x120 VGA adapter among NREQ

---
 rtl/vga_arb_pkg.sv | 22 ++
 rtl/vga_write_arbiter_rr_pick.sv | 33 +++
 rtl/vga_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// Shared constants, state encoding and screen-bounds helper for the VGA pixel-write arbiter.
package vga_arb_pkg;

    localparam int XW_DEF   = 8;
    localparam int YW_DEF   = 7;
    localparam int CW_DEF   = 12;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int OWNER_W  = 3;
    localparam int CLIP_W   = 8;

    typedef enum logic [0:0] {
        IDLE_RR = 1'b0,
        LOCKED  = 1'b1
    } arb_state_e;

    // True when a coordinate pair falls outside the visible 160x120 frame.
    function automatic logic is_offscreen(input logic [15:0] x, input logic [15:0] y);
        return (x >= 16'(SCREEN_W)) || (y >= 16'(SCREEN_H));
    endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after the last-served index, with wrap.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    logic [PW-1:0] cand_s;

    // Scan last+1 .. last+NREQ (mod NREQ); the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = PW'((int'(last_i) + k) % NREQ);
            if (!valid_o && req_i[cand_s]) begin
                valid_o        = 1'b1;
                idx_o          = cand_s;
                gnt_o[cand_s]  = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter with burst lock sharing the VGA adapter pixel-write port among NREQ engines.
// Define VGA_ARB_CLIP_EN to drop (and count) off-screen pixels instead of plotting them.
module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int NREQ         = 3,
    parameter int XW           = XW_DEF,
    parameter int YW           = YW_DEF,
    parameter int CW           = CW_DEF,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [NREQ*XW-1:0]  x_in,
    input  logic [NREQ*YW-1:0]  y_in,
    input  logic [NREQ*CW-1:0]  colour_in,
    output logic [NREQ-1:0]     grant,
    output logic [XW-1:0]       vga_x,
    output logic [YW-1:0]       vga_y,
    output logic [CW-1:0]       vga_colour,
    output logic                vga_plot,
    output logic [OWNER_W-1:0]  owner,
    output logic                locked,
    output logic [CLIP_W-1:0]   clip_cnt
);

    localparam int IW = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [OWNER_W-1:0] ptr_q, ptr_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [CW-1:0]      col_q, col_d;
    logic               plot_q, plot_d;

    logic [NREQ-1:0]    rr_gnt_s;
    logic [OWNER_W-1:0] rr_idx_s;
    logic               rr_valid_s;
    logic [NREQ-1:0]    grant_s;
    logic [OWNER_W-1:0] gidx_s;
    logic               gvalid_s;
    logic [XW-1:0]      x_sel_s;
    logic [YW-1:0]      y_sel_s;
    logic [CW-1:0]      col_sel_s;
    logic               clip_s;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (OWNER_W)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (ptr_q),
        .gnt_o   (rr_gnt_s),
        .idx_o   (rr_idx_s),
        .valid_o (rr_valid_s)
    );

    // Arbitration FSM: next state, grant vector and lock idle counter.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        idle_d   = idle_q;
        grant_s  = '0;
        gidx_s   = owner_q;
        gvalid_s = 1'b0;
        case (state_q)
            IDLE_RR: begin
                idle_d = '0;
                if (rr_valid_s) begin
                    grant_s  = rr_gnt_s;
                    gidx_s   = rr_idx_s;
                    gvalid_s = 1'b1;
                    ptr_d    = rr_idx_s;
                    owner_d  = rr_idx_s;
                    if (lock[rr_idx_s]) begin
                        state_d = LOCKED;
                    end else begin
                        state_d = IDLE_RR;
                    end
                end else begin
                    state_d = IDLE_RR;
                end
            end
            LOCKED: begin
                if (req[owner_q]) begin
                    grant_s[owner_q] = 1'b1;
                    gvalid_s         = 1'b1;
                    idle_d           = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
                // Release happens on the edge where the idle count reaches the timeout.
                if (!lock[owner_q] || (!req[owner_q] && (idle_d == IW'(LOCK_TIMEOUT)))) begin
                    state_d = IDLE_RR;
                    idle_d  = '0;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE_RR;
                idle_d  = '0;
            end
        endcase
    end

    assign x_sel_s   = x_in[int'(gidx_s)*XW +: XW];
    assign y_sel_s   = y_in[int'(gidx_s)*YW +: YW];
    assign col_sel_s = colour_in[int'(gidx_s)*CW +: CW];

`ifdef VGA_ARB_CLIP_EN
    logic [CLIP_W-1:0] clip_q, clip_d;

    assign clip_s = gvalid_s && is_offscreen(16'(x_sel_s), 16'(y_sel_s));

    // Saturating clipped-pixel counter.
    always_comb begin
        if (clip_s && (clip_q != {CLIP_W{1'b1}})) begin
            clip_d = clip_q + CLIP_W'(1);
        end else begin
            clip_d = clip_q;
        end
    end

    // Clip counter register; only reset clears it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clip_q <= '0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip_cnt = clip_q;
`else
    assign clip_s   = 1'b0;
    assign clip_cnt = {CLIP_W{1'b0}};
`endif

    // Pixel output stage: load on an accepted, visible pixel; otherwise hold coordinates.
    always_comb begin
        plot_d = gvalid_s && !clip_s;
        if (plot_d) begin
            x_d   = x_sel_s;
            y_d   = y_sel_s;
            col_d = col_sel_s;
        end else begin
            x_d   = x_q;
            y_d   = y_q;
            col_d = col_q;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE_RR;
            ptr_q   <= OWNER_W'(NREQ - 1);
            owner_q <= '0;
            idle_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            idle_q  <= idle_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
        end
    end

    // Grant is forced low while reset is asserted so every output reads 0 in reset.
    assign grant      = resetn ? grant_s : '0;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;
    assign vga_plot   = plot_q;
    assign owner      = owner_q;
    assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: directed scenarios plus random traffic against a reference model.
module tb_vga_write_arbiter;

    localparam int NREQ = 3;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 12;
    localparam int TMO  = 15;
`ifdef VGA_ARB_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [NREQ*XW-1:0]  x_in;
    logic [NREQ*YW-1:0]  y_in;
    logic [NREQ*CW-1:0]  colour_in;
    logic [NREQ-1:0]     grant;
    logic [XW-1:0]       vga_x;
    logic [YW-1:0]       vga_y;
    logic [CW-1:0]       vga_colour;
    logic                vga_plot;
    logic [2:0]          owner;
    logic                locked;
    logic [7:0]          clip_cnt;

    logic [XW-1:0] px [NREQ];
    logic [YW-1:0] py [NREQ];
    logic [CW-1:0] pc [NREQ];

    always #5 clock = ~clock;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign x_in[i*XW +: XW]      = px[i];
        assign y_in[i*YW +: YW]      = py[i];
        assign colour_in[i*CW +: CW] = pc[i];
    end

    vga_write_arbiter #(
        .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clock(clock), .resetn(resetn), .req(req), .lock(lock),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .grant(grant), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .owner(owner), .locked(locked), .clip_cnt(clip_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit            m_locked;
    int            m_ptr, m_owner, m_idle, m_clip;
    bit            m_plot;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    logic [CW-1:0] m_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_ptr = NREQ - 1; m_owner = 0; m_idle = 0; m_clip = 0;
        m_plot = 1'b0; m_x = '0; m_y = '0; m_c = '0;
    endtask

    // Who should be granted right now, from the arbitration rules.
    function automatic int model_pick();
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_edge(input int g);
        if (g >= 0) begin
            if (CLIP && (px[g] >= 160 || py[g] >= 120)) begin
                m_plot = 1'b0;
                if (m_clip < 255) m_clip++;
            end else begin
                m_plot = 1'b1; m_x = px[g]; m_y = py[g]; m_c = pc[g];
            end
        end else begin
            m_plot = 1'b0;
        end
        if (!m_locked) begin
            if (g >= 0) begin
                m_ptr = g; m_owner = g; m_locked = lock[g]; m_idle = 0;
            end
        end else begin
            if (g >= 0) m_idle = 0; else m_idle++;
            if (!lock[m_owner] || m_idle == TMO) begin
                m_locked = 1'b0; m_idle = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] eg;
        int g;
        g  = model_pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("grant", grant, eg);
        chk("vga_plot", vga_plot, m_plot);
        chk("vga_x", vga_x, m_x);
        chk("vga_y", vga_y, m_y);
        chk("vga_colour", vga_colour, m_c);
        chk("owner", owner, m_owner);
        chk("locked", locked, m_locked);
        chk("clip_cnt", clip_cnt, m_clip);
    endtask

    // Called at a falling edge with inputs set; returns model pick and the DUT grant seen.
    task automatic step(output int g, output logic [NREQ-1:0] gs);
        #1;
        gs = grant;
        check_all();
        g = model_pick();
        @(posedge clock);
        model_edge(g);
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0; req = '0; lock = '0;
        for (int i = 0; i < NREQ; i++) begin px[i] = '0; py[i] = '0; pc[i] = '0; end
        model_reset();
        #13;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        int g, n_idle;
        logic [NREQ-1:0] gs;
        bit pend [NREQ];

        do_reset();
        #1;
        chk("rst_plot", vga_plot, 1'b0);
        chk("rst_owner", owner, 3'd0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_x", vga_x, 8'd0);

        // 1: all request, no lock -> strict rotation from requester 0
        req = 3'b111;
        step(g, gs); chk("t1_g0", gs, 3'b001); chk("t1_plot0", vga_plot, 1'b1);
        step(g, gs); chk("t1_g1", gs, 3'b010); chk("t1_plot1", vga_plot, 1'b1);
        step(g, gs); chk("t1_g2", gs, 3'b100); chk("t1_plot2", vga_plot, 1'b1);
        step(g, gs); chk("t1_g3", gs, 3'b001); chk("t1_plot3", vga_plot, 1'b1);
        req = '0;
        step(g, gs);

        // 2: single pixel from requester 1
        px[1] = 8'd5; py[1] = 7'd7; pc[1] = 12'hF00; req = 3'b010;
        step(g, gs); chk("t2_grant", gs, 3'b010);
        chk("t2_x", vga_x, 8'd5); chk("t2_y", vga_y, 7'd7);
        chk("t2_col", vga_colour, 12'hF00); chk("t2_plot", vga_plot, 1'b1);
        req = '0;
        step(g, gs); chk("t2_plot_off", vga_plot, 1'b0); chk("t2_hold_x", vga_x, 8'd5);

        // 3: requester 2 bursts four pixels while requester 0 waits
        req = 3'b101;
        for (int k = 0; k < 4; k++) begin
            px[2] = 8'(10 + k); py[2] = 7'd20; pc[2] = 12'h0F0;
            lock = (k < 3) ? 3'b100 : 3'b000;
            step(g, gs); chk("t3_burst", gs, 3'b100);
            chk("t3_burst_x", vga_x, 8'(10 + k));
        end
        req = 3'b001; lock = '0;
        step(g, gs); chk("t3_after", gs, 3'b001);

        // 4: locked owner goes quiet -> forced release after the timeout
        req = 3'b100; lock = 3'b100;
        step(g, gs); chk("t4_take", gs, 3'b100); chk("t4_locked", locked, 1'b1);
        req = 3'b001;
        n_idle = 0;
        for (int k = 0; k < 40 && locked === 1'b1; k++) begin
            step(g, gs); chk("t4_blocked", gs, 3'b000);
            n_idle++;
        end
        chk("t4_idle_cycles", n_idle, TMO);
        step(g, gs); chk("t4_waiter", gs, 3'b001);
        req = '0; lock = '0;
        step(g, gs);

        // 6: reset in the middle of a locked burst
        req = 3'b010; lock = 3'b010;
        step(g, gs); step(g, gs);
        chk("t6_pre_locked", locked, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_grant", grant, 3'b000); chk("t6_locked", locked, 1'b0);
        chk("t6_plot", vga_plot, 1'b0); chk("t6_x", vga_x, 8'd0);
        chk("t6_owner", owner, 3'd0);
        model_reset();
        req = '0; lock = '0;
        @(negedge clock);
        resetn = 1'b1;
        req = 3'b111;
        step(g, gs); chk("t6_first", gs, 3'b001);
        req = '0;
        step(g, gs);

        // 5: off-screen pixel handling
        do_reset();
        px[0] = 8'd200; py[0] = 7'd10; pc[0] = 12'h123; req = 3'b001;
        step(g, gs); chk("t5_grant", gs, 3'b001);
`ifdef VGA_ARB_CLIP_EN
        chk("t5_plot", vga_plot, 1'b0); chk("t5_clip1", clip_cnt, 8'd1);
        for (int k = 0; k < 300; k++) step(g, gs);
        chk("t5_sat", clip_cnt, 8'd255);
`else
        chk("t5_plot", vga_plot, 1'b1); chk("t5_x", vga_x, 8'd200);
        chk("t5_clip0", clip_cnt, 8'd0);
`endif
        req = '0;
        step(g, gs);

        // Random traffic: engines hold each pixel until granted, locks toggle randomly
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i] = 1'b1;
                    px[i] = 8'($urandom_range(0, 200));
                    py[i] = 7'($urandom_range(0, 127));
                    pc[i] = 12'($urandom);
                end
                if ($urandom_range(0, 99) < 12) lock[i] = ~lock[i];
                req[i] = pend[i];
            end
            step(g, gs);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
